// File: rtl/cr16_ctrl_pkg.sv
// Shared types for the CR16 control path: sequencer states, decoded
// instruction classes and small class-decode helpers.
package cr16_ctrl_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned CLASS_W   = 3;
  localparam int unsigned RETIRED_W = 16;

  typedef enum logic [STATE_W-1:0] {
    S_RESET     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_e;

  typedef enum logic [CLASS_W-1:0] {
    ALU     = 3'd0,
    LOAD    = 3'd1,
    STORE   = 3'd2,
    BRANCH  = 3'd3,
    JUMP    = 3'd4,
    JAL     = 3'd5,
    HALT    = 3'd6,
    ILLEGAL = 3'd7
  } instr_class_e;

  // Redirect the PC to the target instead of incrementing.
  function automatic logic is_jump(input instr_class_e cls, input logic taken);
    return ((cls == BRANCH) && taken) || (cls == JUMP) || (cls == JAL);
  endfunction

  // Classes that commit a register result in writeback.
  function automatic logic writes_reg(input instr_class_e cls);
    return (cls == ALU) || (cls == LOAD) || (cls == JAL);
  endfunction

endpackage

// File: rtl/pc_ctrl.sv
// pc_ctrl: multi-cycle instruction sequencer driving the PC, IR and memory.
// Ports:
//   I_CLK, I_RESET (sync, active-high), I_ENABLE (low freezes everything)
//   I_MEM_READY              memory acknowledge, honoured in FETCH and MEM only
//   I_INSTR_TYPE             decoded instruction class (cr16_ctrl_pkg)
//   I_BRANCH_TAKEN, I_TARGET sampled in EXECUTE
//   O_PC_*                   PC enable / clear / mux selects / registered target
//   O_IR_LOAD, O_MEM_READ, O_MEM_WRITE, O_ADDR_SRC, O_REG_WRITE, O_HALTED
//   O_STATE                  current state for debug
//   O_RETIRED                retired-instruction count (wraps)
module pc_ctrl
  import cr16_ctrl_pkg::*;
#(
  parameter int unsigned P_ADDRESS_WIDTH = 16
) (
  input  logic                       I_CLK,
  input  logic                       I_RESET,
  input  logic                       I_ENABLE,
  input  logic                       I_MEM_READY,
  input  logic [CLASS_W-1:0]         I_INSTR_TYPE,
  input  logic                       I_BRANCH_TAKEN,
  input  logic [P_ADDRESS_WIDTH-1:0] I_TARGET,
  output logic                       O_PC_ENABLE,
  output logic                       O_PC_NRESET,
  output logic                       O_PC_ADDRESS_SELECT,
  output logic                       O_PC_ADDRESS_SELECT_INCREMENT,
  output logic [P_ADDRESS_WIDTH-1:0] O_PC_ADDRESS,
  output logic                       O_IR_LOAD,
  output logic                       O_MEM_READ,
  output logic                       O_MEM_WRITE,
  output logic                       O_ADDR_SRC,
  output logic                       O_REG_WRITE,
  output logic                       O_HALTED,
  output logic [STATE_W-1:0]         O_STATE,
  output logic [RETIRED_W-1:0]       O_RETIRED
);

  state_e                     state_q,   state_d;
  instr_class_e               instr_q,   instr_d;
  logic                       jump_q,    jump_d;
  logic [P_ADDRESS_WIDTH-1:0] pc_addr_q, pc_addr_d;
  logic [RETIRED_W-1:0]       retired_q, retired_d;

  instr_class_e cls;
  assign cls = instr_class_e'(I_INSTR_TYPE);

  // Next-state and datapath register updates; nothing moves while disabled.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    jump_d    = jump_q;
    pc_addr_d = pc_addr_q;
    retired_d = retired_q;
    if (I_ENABLE) begin
      unique case (state_q)
        S_RESET:     state_d = S_FETCH;
        S_FETCH:     if (I_MEM_READY) state_d = S_DECODE;
        S_DECODE:    state_d = S_EXECUTE;
        S_EXECUTE: begin
          // Class is latched so MEM/WRITEBACK do not depend on the decoder holding it.
          instr_d   = cls;
          jump_d    = is_jump(cls, I_BRANCH_TAKEN);
          pc_addr_d = I_TARGET;
          unique case (cls)
            LOAD, STORE: state_d = S_MEM;
            HALT:        state_d = S_HALT;
            default:     state_d = S_WRITEBACK;
          endcase
        end
        S_MEM:       if (I_MEM_READY) state_d = S_WRITEBACK;
        S_WRITEBACK: begin
          retired_d = retired_q + RETIRED_W'(1);
          state_d   = S_FETCH;
        end
        S_HALT:      state_d = S_HALT;
        default:     state_d = S_RESET;
      endcase
    end
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q   <= S_RESET;
      instr_q   <= ALU;
      jump_q    <= 1'b0;
      pc_addr_q <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      jump_q    <= jump_d;
      pc_addr_q <= pc_addr_d;
      retired_q <= retired_d;
    end
  end

  // Output decode from state; IR load is the only input-dependent strobe.
  always_comb begin
    O_PC_ENABLE                   = 1'b0;
    O_PC_NRESET                   = 1'b1;
    O_PC_ADDRESS_SELECT           = 1'b0;
    // The sequencer always expresses "next PC" via select=0, never via this mux leg.
    O_PC_ADDRESS_SELECT_INCREMENT = 1'b0;
    O_IR_LOAD                     = 1'b0;
    O_MEM_READ                    = 1'b0;
    O_MEM_WRITE                   = 1'b0;
    O_ADDR_SRC                    = 1'b0;
    O_REG_WRITE                   = 1'b0;
    O_HALTED                      = 1'b0;
    unique case (state_q)
      S_RESET: begin
        O_PC_ENABLE = 1'b1;
        O_PC_NRESET = 1'b0;
      end
      S_FETCH: begin
        O_MEM_READ = 1'b1;
        O_IR_LOAD  = I_MEM_READY;
      end
      S_MEM: begin
        O_ADDR_SRC  = 1'b1;
        O_MEM_READ  = (instr_q == LOAD);
        O_MEM_WRITE = (instr_q == STORE);
      end
      S_WRITEBACK: begin
        O_PC_ENABLE         = 1'b1;
        O_PC_ADDRESS_SELECT = jump_q;
        O_REG_WRITE         = writes_reg(instr_q);
      end
      S_HALT:  O_HALTED = 1'b1;
      default: ;
    endcase
    // Disabled: suppress every side-effecting strobe so the pending access re-issues later.
    if (!I_ENABLE) begin
      O_PC_ENABLE = 1'b0;
      O_IR_LOAD   = 1'b0;
      O_REG_WRITE = 1'b0;
      O_MEM_READ  = 1'b0;
      O_MEM_WRITE = 1'b0;
    end
  end

  assign O_PC_ADDRESS = pc_addr_q;
  assign O_STATE      = state_q;
  assign O_RETIRED    = retired_q;

endmodule
